heli_motion_ctrl: RTL
=====================

Name: heli_motion_ctrl

Overview:
Game-state and motion stage directly upstream of helicopter_drawer. Produces the helicopter anchor position (x_heli, y_heli) that the drawer consumes as x_mouse / y_mouse.
Once per video frame, applies lift or gravity to a signed vertical velocity and integrates it into y. Clamps y to the screen and detects crashes.
Runs a small IDLE/FLYING/CRASHED game state machine.

Parameters:
X_START, 100, fixed helicopter x anchor (pixels)
Y_START, 200, y anchor on reset/restart
HELI_H, 15, sprite height in rows (rows y..y+14)
Y_MAX, 479, last visible screen row
GRAVITY, 1, velocity increment per frame when fly=0
LIFT, 2, velocity decrement per frame when fly=1
VMAX, 6, velocity magnitude limit (|vel| <= VMAX)

Ports:
clk  in  1  system/pixel clock
reset  in  1  synchronous, active-high
frame_tick  in  1  one-cycle pulse per frame, issued at start of vertical blank
fly  in  1  level; 1 = lift requested (mouse/key held)
start  in  1  one-cycle pulse; begin or restart a game
hit  in  1  level; helicopter pixel overlaps an obstacle pixel this cycle
x_heli  out  10  helicopter x anchor (constant X_START)
y_heli  out  9  helicopter y anchor, range 0..Y_MAX-HELI_H+1 (465 default)
playing  out  1  1 while in FLYING
crashed  out  1  1 while in CRASHED
score  out  16  frames survived (only with HELI_SCORE_EN)

Behaviour:
- Clock and reset: one clock `clk`; reset is synchronous and active-high on `reset`. All state updates on posedge clk.
- Reset values:
  - state = IDLE, y_heli = Y_START, vel = 0
  - playing = 0, crashed = 0, score = 0
  - x_heli = X_START at all times
- Velocity: internal signed 5-bit `vel`. Position math uses signed 11-bit intermediate `y_next = y_heli + vel_new`.
- State IDLE:
  - Outputs hold.
  - start=1 -> FLYING next cycle; y_heli = Y_START, vel = 0, score = 0.
  - frame_tick and hit are ignored.
- State FLYING:
  - On frame_tick with fly=1: vel_new = max(vel - LIFT, -VMAX).
  - On frame_tick with fly=0: vel_new = min(vel + GRAVITY, VMAX).
  - The registered y_heli and vel are updated 1 cycle after frame_tick. y_heli is otherwise stable for the whole frame.
  - If y_next < 0: y_heli = 0 and go to CRASHED.
  - If y_next > Y_MAX-HELI_H+1: y_heli = Y_MAX-HELI_H+1 and go to CRASHED.
  - Otherwise score += 1, saturating at 16'hFFFF.
- Crash on hit: hit=1 in any FLYING cycle -> CRASHED next cycle.
  - hit has priority over a simultaneous frame_tick: no position, velocity or score update that cycle.
- State CRASHED:
  - y_heli, vel and score frozen; crashed = 1.
  - start=1 -> FLYING, with the same reinitialisation as from IDLE.
  - hit and frame_tick are ignored.
- Start while FLYING: restarts, reinitialising y_heli, vel and score. It wins over hit and frame_tick in the same cycle.
- Reset mid-game: returns to IDLE next edge regardless of other inputs.
- Output encoding: playing and crashed are decoded from registered state, so they are glitch-free and never both 1.

Optional Feature:
- Macro: HELI_SCORE_EN.
- Defined: `score` port exists and counts as specified above.
- Undefined: `score` port and counter are removed; all other behaviour is identical.

Test Plan:
- Reset, then start, then 3 frame_ticks with fly=0 -> vel 1,2,3 and y_heli 201,203,206. playing=1.
- From restart, 4 frame_ticks with fly=1 -> vel -2,-4,-6,-6 and y_heli 198,194,188,182 (VMAX saturation).
- Fly held from y=5, vel=-6 -> y_heli=0, crashed=1, playing=0. Further ticks leave y_heli=0.
- Falling with fly=0 until the bottom -> y_heli clamps at 465 and crashed=1. Then start -> y_heli=200, vel=0, playing=1.
- hit and frame_tick in the same cycle during FLYING -> CRASHED next cycle, y_heli unchanged, score unchanged.
- 10 clean ticks then hit (HELI_SCORE_EN defined) -> score=10 frozen. Then reset -> score=0, state IDLE, y_heli=200.

Source files
------------

// File: rtl/heli_motion_if.sv
// Control and position bundle between the game front end and heli_motion_ctrl.
// The score signal exists only when HELI_SCORE_EN is defined.
interface heli_motion_if;
    logic        frame_tick;
    logic        fly;
    logic        start;
    logic        hit;
    logic [9:0]  x_heli;
    logic [8:0]  y_heli;
    logic        playing;
    logic        crashed;
`ifdef HELI_SCORE_EN
    logic [15:0] score;

    modport master (
        output frame_tick, fly, start, hit,
        input  x_heli, y_heli, playing, crashed, score
    );
    modport slave (
        input  frame_tick, fly, start, hit,
        output x_heli, y_heli, playing, crashed, score
    );
`else
    modport master (
        output frame_tick, fly, start, hit,
        input  x_heli, y_heli, playing, crashed
    );
    modport slave (
        input  frame_tick, fly, start, hit,
        output x_heli, y_heli, playing, crashed
    );
`endif
endinterface

// File: rtl/heli_motion_ctrl.sv
// Per-frame helicopter motion and IDLE/FLYING/CRASHED game state.
// Optional frames-survived counter enabled by the HELI_SCORE_EN macro.
module heli_motion_ctrl #(
    parameter int X_START = 100,
    parameter int Y_START = 200,
    parameter int HELI_H  = 15,
    parameter int Y_MAX   = 479,
    parameter int GRAVITY = 1,
    parameter int LIFT    = 2,
    parameter int VMAX    = 6
) (
    input  logic          clk,
    input  logic          reset,
    heli_motion_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FLYING  = 2'd1,
        CRASHED = 2'd2
    } state_t;

    localparam logic signed [5:0]  GRAV_S  = 6'(GRAVITY);
    localparam logic signed [5:0]  LIFT_S  = 6'(LIFT);
    localparam logic signed [5:0]  VMAX_S  = 6'(VMAX);
    localparam logic signed [10:0] Y_LIM_S = 11'(Y_MAX - HELI_H + 1);
    localparam logic [8:0]         Y_LIM   = 9'(Y_MAX - HELI_H + 1);
    localparam logic [8:0]         Y_INIT  = 9'(Y_START);

    state_t             state;
    logic [8:0]         y_q;
    logic signed [4:0]  vel;
    logic signed [5:0]  vel_sum;
    logic signed [4:0]  vel_new;
    logic signed [10:0] y_next;

    // One bit of headroom so the saturation compare sees the true overshoot.
    always_comb begin
        vel_sum = fly_sel(bus.fly) ? ({vel[4], vel} - LIFT_S) : ({vel[4], vel} + GRAV_S);
        if (vel_sum > VMAX_S)
            vel_sum = VMAX_S;
        else if (vel_sum < -VMAX_S)
            vel_sum = -VMAX_S;
        vel_new = vel_sum[4:0];
        y_next  = $signed({2'b00, y_q}) + $signed({{6{vel_new[4]}}, vel_new});
    end

    function automatic logic fly_sel(input logic f);
        return f;
    endfunction

`ifdef HELI_SCORE_EN
    logic [15:0] score_q;
    assign bus.score = score_q;
`endif

    // NOTE: all state below uses non-blocking assignments so every register
    // samples the pre-edge values; y_next is computed combinationally above.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            y_q   <= Y_INIT;
            vel   <= '0;
`ifdef HELI_SCORE_EN
            score_q <= '0;
`endif
        end else begin
            if (bus.start) begin
                // Start reinitialises from any state and beats hit/frame_tick.
                state <= FLYING;
                y_q   <= Y_INIT;
                vel   <= '0;
`ifdef HELI_SCORE_EN
                score_q <= '0;
`endif
            end else if (state == FLYING) begin
                if (bus.hit) begin
                    state <= CRASHED;
                end else if (bus.frame_tick) begin
                    vel <= vel_new;
                    if (y_next < 0) begin
                        y_q   <= '0;
                        state <= CRASHED;
                    end else if (y_next > Y_LIM_S) begin
                        y_q   <= Y_LIM;
                        state <= CRASHED;
                    end else begin
                        y_q <= y_next[8:0];
`ifdef HELI_SCORE_EN
                        if (score_q != 16'hFFFF)
                            score_q <= score_q + 16'd1;
`endif
                    end
                end
            end
        end
    end

    assign bus.x_heli  = 10'(X_START);
    assign bus.y_heli  = y_q;
    assign bus.playing = (state == FLYING);
    assign bus.crashed = (state == CRASHED);

endmodule
